// File: rtl/md_pkg.sv
// Shared types and word-layout constants for the market data packer and parser.
package md_pkg;

    localparam logic [7:0] MD_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] PAYLOAD_LEN  = 8'd2;

    // Bit positions inside the 32-bit message words (parser uses the same layout)
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_SIDE_BIT = 15;
    localparam int HDR_LEN_LSB  = 0;
    localparam int SYM_LSB      = 16;
    localparam int PRICE_LSB    = 0;
    localparam int QTY_LSB      = 16;
    localparam int TAIL_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY,
        TAIL
    } md_state_t;

    typedef enum logic [2:0] {
        LOAD_NONE,
        LOAD_W0,
        LOAD_W1,
        LOAD_W2,
        LOAD_CLEAR
    } md_load_t;

    typedef struct packed {
        logic [15:0] symbol;
        logic [15:0] price;
        logic [15:0] qty;
        logic        side;
    } quote_t;

    localparam int QUOTE_W = $bits(quote_t);

    function automatic logic [31:0] build_hdr(input logic [7:0] sync_byte,
                                              input logic [7:0] seq,
                                              input logic       side);
        logic [31:0] w;
        w = '0;
        w[HDR_SYNC_LSB +: 8] = sync_byte;
        w[HDR_SEQ_LSB +: 8]  = seq;
        w[HDR_SIDE_BIT]      = side;
        w[HDR_LEN_LSB +: 8]  = PAYLOAD_LEN;
        return w;
    endfunction

    function automatic logic [31:0] build_body(input logic [15:0] symbol,
                                               input logic [15:0] price);
        logic [31:0] w;
        w = '0;
        w[SYM_LSB +: 16]   = symbol;
        w[PRICE_LSB +: 16] = price;
        return w;
    endfunction

    function automatic logic [31:0] build_tail(input logic [15:0] qty,
                                               input logic [15:0] tail16);
        logic [31:0] w;
        w = '0;
        w[QTY_LSB +: 16]  = qty;
        w[TAIL_LSB +: 16] = tail16;
        return w;
    endfunction

endpackage

// File: rtl/md_quote_fifo.sv
// First-word-fall-through quote buffer; head_data is valid whenever empty is low.
module md_quote_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;
    logic [DEPTH-1:0] wr_en;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= push_data;
            end
        end
    end

    assign head_data = mem[rd_ptr_reg];

    // Fullness is judged on the registered count, so a pop never frees room for a same-cycle push
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/market_data_packer.sv
// Serialises buffered quotes into 3-word framed messages on a valid/ready stream.
// Define MD_CKSUM_EN to replace the zero tail of word 2 with an XOR checksum.
module market_data_packer
    import md_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = MD_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        quote_valid,
    output logic        quote_ready,
    input  logic [15:0] symbol,
    input  logic [15:0] price,
    input  logic [15:0] qty,
    input  logic        side,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_last,
    output logic [15:0] msgs_sent
);

    md_state_t   state_reg;
    md_state_t   state_next;
    md_load_t    load_sel;
    logic        fifo_pop;
    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic        msg_done;
    logic        xfer;
    quote_t      quote_in;
    quote_t      fifo_head;

    logic [31:0] data_out_reg;
    logic        data_valid_reg;
    logic        data_last_reg;
    logic [7:0]  seq_reg;
    logic [15:0] msgs_sent_reg;
    logic [15:0] symbol_reg;
    logic [15:0] price_reg;
    logic [15:0] qty_reg;
    logic [7:0]  seq_hdr;
    logic [31:0] hdr_word;
    logic [15:0] tail_word;

    assign quote_in  = '{symbol: symbol, price: price, qty: qty, side: side};
    assign fifo_push = quote_valid && !fifo_full;
    assign xfer      = data_valid_reg && data_ready;

    md_quote_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (QUOTE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (quote_in),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!fifo_empty) state_next = HDR;
            HDR:  if (xfer) state_next = BODY;
            BODY: if (xfer) state_next = TAIL;
            TAIL: if (xfer) state_next = fifo_empty ? IDLE : HDR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        load_sel = LOAD_NONE;
        msg_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load_sel = LOAD_W0;
                end
            end
            HDR:  if (xfer) load_sel = LOAD_W1;
            BODY: if (xfer) load_sel = LOAD_W2;
            TAIL: begin
                if (xfer) begin
                    msg_done = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        load_sel = LOAD_W0;
                    end else begin
                        load_sel = LOAD_CLEAR;
                    end
                end
            end
            default: ;
        endcase
    end

    // A header loaded back-to-back from TAIL must carry the already-incremented sequence
    assign seq_hdr  = msg_done ? seq_reg + 8'd1 : seq_reg;
    assign hdr_word = build_hdr(SYNC_BYTE, seq_hdr, fifo_head.side);

`ifdef MD_CKSUM_EN
    logic [15:0] tail_reg;
    logic [15:0] tail_calc;

    assign tail_calc = hdr_word[31:16] ^ hdr_word[15:0] ^ fifo_head.symbol
                     ^ fifo_head.price ^ fifo_head.qty;

    always_ff @(posedge clk) begin
        if (reset) begin
            tail_reg <= '0;
        end else if (load_sel == LOAD_W0) begin
            tail_reg <= tail_calc;
        end
    end

    assign tail_word = tail_reg;
`else
    assign tail_word = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            data_last_reg  <= 1'b0;
            seq_reg        <= '0;
            msgs_sent_reg  <= '0;
            symbol_reg     <= '0;
            price_reg      <= '0;
            qty_reg        <= '0;
        end else begin
            if (msg_done) begin
                seq_reg       <= seq_reg + 8'd1;
                msgs_sent_reg <= msgs_sent_reg + 16'd1;
            end
            case (load_sel)
                LOAD_W0: begin
                    data_out_reg   <= hdr_word;
                    data_valid_reg <= 1'b1;
                    data_last_reg  <= 1'b0;
                    symbol_reg     <= fifo_head.symbol;
                    price_reg      <= fifo_head.price;
                    qty_reg        <= fifo_head.qty;
                end
                LOAD_W1: begin
                    data_out_reg <= build_body(symbol_reg, price_reg);
                end
                LOAD_W2: begin
                    data_out_reg  <= build_tail(qty_reg, tail_word);
                    data_last_reg <= 1'b1;
                end
                LOAD_CLEAR: begin
                    data_valid_reg <= 1'b0;
                    data_last_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quote_ready = !fifo_full;
    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign data_last   = data_last_reg;
    assign msgs_sent   = msgs_sent_reg;

endmodule

// File: tb/tb_market_data_packer.sv
// Directed bench for market_data_packer; honours MD_CKSUM_EN for the expected tail.
module tb_market_data_packer;

`ifdef MD_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        quote_valid = 1'b0;
    logic        quote_ready;
    logic [15:0] symbol = '0;
    logic [15:0] price = '0;
    logic [15:0] qty = '0;
    logic        side = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        data_last;
    logic [15:0] msgs_sent;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    market_data_packer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .quote_valid (quote_valid),
        .quote_ready (quote_ready),
        .symbol      (symbol),
        .price       (price),
        .qty         (qty),
        .side        (side),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_last   (data_last),
        .msgs_sent   (msgs_sent)
    );

    function automatic logic [31:0] exp_hdr(input logic [7:0] s, input logic sd);
        return {8'hA5, s, sd, 7'b0, 8'd2};
    endfunction

    function automatic logic [15:0] exp_tail(input logic [31:0] h, input logic [15:0] sy,
                                             input logic [15:0] pr, input logic [15:0] q);
        return CKSUM_EN ? (h[31:16] ^ h[15:0] ^ sy ^ pr ^ q) : 16'h0000;
    endfunction

    // Leaves the caller 1ns after a rising edge with reset released
    task automatic apply_reset();
        reset = 1'b1;
        quote_valid = 1'b0;
        data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Must be called 1ns after a rising edge; the quote is offered for exactly one edge
    task automatic push_quote(input logic [15:0] s, input logic [15:0] p,
                              input logic [15:0] q, input logic sd);
        symbol = s;
        price = p;
        qty = q;
        side = sd;
        quote_valid = 1'b1;
        @(posedge clk);
        #1 quote_valid = 1'b0;
    endtask

    // Waits (bounded) for the next word that will transfer; gap = idle cycles, -1 on timeout
    task automatic next_word(output logic [31:0] w, output logic l, output int gap);
        bit done;
        done = 1'b0;
        gap = 0;
        w = '0;
        l = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (data_valid && data_ready) begin
                w = data_out;
                l = data_last;
                done = 1'b1;
            end else begin
                gap++;
                if (gap > 100) begin
                    gap = -1;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total += 5;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        if (data_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", data_last); end
        if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
        if (msgs_sent !== 16'h0) begin bad++; $display("FAIL reset_msgs got=%0d exp=0", msgs_sent); end
        if (quote_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", quote_ready); end
        $display("test_reset: checked reset state");
    endtask

    task automatic test_single();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA500_8002;
        exp_w[1] = 32'h1234_00FF;
        exp_w[2] = {16'h0010, CKSUM_EN ? (16'hA500 ^ 16'h8002 ^ 16'h1234 ^ 16'h00FF ^ 16'h0010) : 16'h0000};
        apply_reset();
        data_ready = 1'b1;
        push_quote(16'h1234, 16'h00FF, 16'h0010, 1'b1);
        @(negedge clk);
        total++;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL single_latency valid=%b exp=0", data_valid); end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            total += 3;
            if (data_valid !== 1'b1) begin bad++; $display("FAIL single_valid w%0d got=%b exp=1", w, data_valid); end
            if (data_out !== exp_w[w]) begin bad++; $display("FAIL single_word w%0d got=%h exp=%h", w, data_out, exp_w[w]); end
            if (data_last !== (w == 2)) begin bad++; $display("FAIL single_last w%0d got=%b exp=%b", w, data_last, (w == 2)); end
            $display("test_single: word %0d = %h last=%b", w, data_out, data_last);
        end
        @(negedge clk);
        total += 2;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL single_idle valid=%b exp=0", data_valid); end
        if (msgs_sent !== 16'd1) begin bad++; $display("FAIL single_msgs got=%0d exp=1", msgs_sent); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        data_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    push_quote(16'hA000 + 16'(i), 16'h0100 + 16'(i), 16'h0020 + 16'(i), i[0]);
            end
            begin
                logic [31:0] w, e, h;
                logic l;
                int gap;
                for (int k = 0; k < 12; k++) begin
                    int m;
                    m = k / 3;
                    h = exp_hdr(8'(m), m[0]);
                    case (k % 3)
                        0:       e = h;
                        1:       e = {16'hA000 + 16'(m), 16'h0100 + 16'(m)};
                        default: e = {16'h0020 + 16'(m), exp_tail(h, 16'hA000 + 16'(m), 16'h0100 + 16'(m), 16'h0020 + 16'(m))};
                    endcase
                    next_word(w, l, gap);
                    total += 3;
                    if (w !== e) begin bad++; $display("FAIL b2b_word k%0d got=%h exp=%h", k, w, e); end
                    if (l !== (k % 3 == 2)) begin bad++; $display("FAIL b2b_last k%0d got=%b exp=%b", k, l, (k % 3 == 2)); end
                    if (k > 0 && gap != 0) begin bad++; $display("FAIL b2b_gap k%0d got=%0d exp=0", k, gap); end
                    $display("test_back_to_back: word %0d = %h gap=%0d", k, w, gap);
                    if (gap < 0) break;
                end
            end
        join
        @(negedge clk);
        total++;
        if (msgs_sent !== 16'd4) begin bad++; $display("FAIL b2b_msgs got=%0d exp=4", msgs_sent); end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        logic l;
        int gap;
        apply_reset();
        data_ready = 1'b1;
        push_quote(16'h1234, 16'h00FF, 16'h0010, 1'b1);
        next_word(w, l, gap);
        total++;
        if (w !== 32'hA500_8002) begin bad++; $display("FAIL stall_w0 got=%h exp=a5008002", w); end
        @(posedge clk);
        #1 data_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total += 3;
            if (data_out !== 32'h1234_00FF) begin bad++; $display("FAIL stall_hold c%0d got=%h exp=123400ff", c, data_out); end
            if (data_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=1", c, data_valid); end
            if (data_last !== 1'b0) begin bad++; $display("FAIL stall_last c%0d got=%b exp=0", c, data_last); end
            $display("test_stall: cycle %0d data=%h valid=%b", c, data_out, data_valid);
        end
        data_ready = 1'b1;
        next_word(w, l, gap);
        total += 3;
        if (w !== {16'h0010, exp_tail(32'hA500_8002, 16'h1234, 16'h00FF, 16'h0010)}) begin
            bad++; $display("FAIL stall_w2 got=%h", w);
        end
        if (l !== 1'b1) begin bad++; $display("FAIL stall_w2_last got=%b exp=1", l); end
        if (gap != 0) begin bad++; $display("FAIL stall_resume_gap got=%0d exp=0", gap); end
        @(negedge clk);
        total++;
        if (msgs_sent !== 16'd1) begin bad++; $display("FAIL stall_msgs got=%0d exp=1", msgs_sent); end
    endtask

    task automatic test_full();
        logic [31:0] w, e, h;
        logic l;
        int gap;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (quote_ready !== 1'b1) begin bad++; $display("FAIL full_ready_before q%0d got=%b exp=1", i, quote_ready); end
            push_quote(16'hB000 + 16'(i), 16'h0200 + 16'(i), 16'h0030 + 16'(i), ~i[0]);
        end
        total++;
        if (quote_ready !== 1'b0) begin bad++; $display("FAIL full_ready_after got=%b exp=0", quote_ready); end
        symbol = 16'hDEAD;
        price = 16'hBEEF;
        qty = 16'hFFFF;
        quote_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 quote_valid = 1'b0;
        total += 2;
        if (quote_ready !== 1'b0) begin bad++; $display("FAIL full_ready_hold got=%b exp=0", quote_ready); end
        if (data_out !== exp_hdr(8'd0, 1'b1) || data_valid !== 1'b1) begin
            bad++; $display("FAIL full_w0_hold got=%h valid=%b exp=%h", data_out, data_valid, exp_hdr(8'd0, 1'b1));
        end
        data_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            int m;
            m = k / 3;
            h = exp_hdr(8'(m), ~m[0]);
            case (k % 3)
                0:       e = h;
                1:       e = {16'hB000 + 16'(m), 16'h0200 + 16'(m)};
                default: e = {16'h0030 + 16'(m), exp_tail(h, 16'hB000 + 16'(m), 16'h0200 + 16'(m), 16'h0030 + 16'(m))};
            endcase
            next_word(w, l, gap);
            total++;
            if (w !== e) begin bad++; $display("FAIL full_word k%0d got=%h exp=%h", k, w, e); end
            $display("test_full: word %0d = %h", k, w);
            if (gap < 0) break;
        end
        @(negedge clk);
        total++;
        if (msgs_sent !== 16'd5) begin bad++; $display("FAIL full_msgs got=%0d exp=5", msgs_sent); end
        repeat (3) @(negedge clk);
        total++;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL full_drop_extra valid=%b exp=0", data_valid); end
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        data_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 257; i++) begin
                    int guard;
                    guard = 0;
                    while (!quote_ready && guard < 200) begin
                        @(posedge clk);
                        #1 guard++;
                    end
                    push_quote(16'(i), ~16'(i), 16'(i * 3), i[0]);
                end
            end
            begin
                logic [31:0] w, e, h;
                logic l;
                int gap;
                for (int k = 0; k < 257 * 3; k++) begin
                    int m;
                    m = k / 3;
                    h = exp_hdr(8'(m), m[0]);
                    case (k % 3)
                        0:       e = h;
                        1:       e = {16'(m), ~16'(m)};
                        default: e = {16'(m * 3), exp_tail(h, 16'(m), ~16'(m), 16'(m * 3))};
                    endcase
                    next_word(w, l, gap);
                    total++;
                    if (w !== e) begin bad++; $display("FAIL wrap_word k%0d got=%h exp=%h", k, w, e); end
                    if (k % 3 == 0 && (m == 255 || m == 256))
                        $display("test_seq_wrap: msg %0d header %h", m, w);
                    if (gap < 0) break;
                end
            end
        join
        @(negedge clk);
        total++;
        if (msgs_sent !== 16'd257) begin bad++; $display("FAIL wrap_msgs got=%0d exp=257", msgs_sent); end
        $display("test_seq_wrap: msgs_sent=%0d", msgs_sent);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        logic l;
        int gap;
        int guard;
        apply_reset();
        data_ready = 1'b1;
        push_quote(16'h1111, 16'h2222, 16'h0003, 1'b0);
        push_quote(16'h4444, 16'h5555, 16'h0006, 1'b1);
        push_quote(16'h7777, 16'h8888, 16'h0009, 1'b0);
        guard = 0;
        while (msgs_sent != 16'd1 && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        @(posedge clk);
        #1;
        total++;
        if (data_out !== 32'h4444_5555) begin bad++; $display("FAIL midrst_body got=%h exp=44445555", data_out); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total += 3;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", data_valid); end
        if (quote_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", quote_ready); end
        if (msgs_sent !== 16'd0) begin bad++; $display("FAIL midrst_msgs got=%0d exp=0", msgs_sent); end
        repeat (3) @(negedge clk);
        total++;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL midrst_flush valid=%b exp=0", data_valid); end
        @(posedge clk);
        #1;
        push_quote(16'h9999, 16'hAAAA, 16'h000C, 1'b1);
        next_word(w, l, gap);
        total++;
        if (w !== exp_hdr(8'd0, 1'b1)) begin bad++; $display("FAIL midrst_seq got=%h exp=%h", w, exp_hdr(8'd0, 1'b1)); end
        $display("test_reset_mid: post-reset header %h", w);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full();
        test_seq_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
